memb_writer: RTL and testbench
==============================

# memb_writer

Destination-side writer for the memory transfer path. It accepts the 8-bit result stream that the ALU drives toward memory B, stores each qualified word at consecutive addresses of an on-block RAM, and reports completion to the controller. A registered read port lets the controller or bench read memory B back.

## Interface
- DATA_W, 8: width of each stored word; matches the ALU result width.
- DEPTH, 16: number of words in memory B.
- ADDR_W, 4: address width; must equal clog2(DEPTH).

- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state below.
- start  in  1  begin a transfer; sampled only in IDLE.
- length  in  ADDR_W+1  words to write; sampled with start; values above DEPTH clamp to DEPTH.
- datainB  in  DATA_W  result word from the ALU.
- datain_valid  in  1  datainB qualifier, driven high by the controller on ALU result cycles.
- rd_addr  in  ADDR_W  read-back address.
- rd_data  out  DATA_W  registered read data.
- busy  out  1  high while in FILL.
- done  out  1  one-cycle completion pulse.
- wr_addr  out  ADDR_W  next write address.
- wr_count  out  ADDR_W+1  words written in the current transfer.
- dropped  out  1  sticky; set when datain_valid is high outside FILL.

## Operation
- States: IDLE, FILL, DONE.
- IDLE:
  - start with clamped length 0 → DONE.
  - start with length ≥ 1 → FILL; latch the clamped length; wr_addr and wr_count go to 0; dropped clears.
- FILL, on datain_valid:
  - mem[wr_addr] ← datainB; wr_addr increments; wr_count increments.
  - If wr_count was length−1 before this write → DONE.
  - Cycles without datain_valid hold all state.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start outside IDLE is ignored; it does not retrigger or restart a transfer.
- datain_valid in IDLE or DONE is discarded: no write, and dropped is set.
- Same-cycle start and datain_valid in IDLE: the start is taken, the word is dropped, and dropped stays 0 because start's clear has priority.
- wr_addr wraps DEPTH−1 → 0. This only happens on the final write of a length=DEPTH transfer.
- Read port:
  - rd_data ← mem[rd_addr] every cycle.
  - Read-first: a read and a write to the same address in the same cycle return the old contents.
- Reset values:
  - State IDLE.
  - rd_data, wr_addr, wr_count: 0.
  - busy, done, dropped: 0.
  - RAM contents are not reset.
- Reset mid-FILL: return to IDLE immediately. Words already written remain in RAM. No done pulse is produced.

## Timing
- start at edge 0 → busy=1 from edge 0 onward. A datain_valid in the cycle after edge 0 is the first write.
- Last write at edge k → done=1 and busy=0 during cycle k+1 → IDLE at edge k+1. A new start is accepted at edge k+2 at the earliest.
- length=0: start at edge 0 → done during cycle 1 with no writes and busy never asserted.
- Read latency is 1 cycle: rd_addr at edge n → rd_data valid after edge n+1.
- Maximum sustained rate is one word per cycle. In practice the ALU stream gives one word every two cycles.

## Structure
- Shared package memxfer_pkg holds:
  - the state enum (IDLE/FILL/DONE);
  - DATA_W default 8;
  - memory B DEPTH and ADDR_W constants shared with the controller and the memory A reader.
- One sub-module: memb_ram, a simple dual-port RAM.
  - One write port and one registered read-first read port.
  - No reset on the storage.
- The FSM, counters and the dropped flag live in memb_writer.

## Test plan
- Reset, then start with length=4 and valid on alternate cycles with data 8'h11, 8'h22, 8'h33, 8'h44 → done pulses once, one cycle after the 4th write; read-back of addresses 0..3 = 11, 22, 33, 44; wr_count=4.
- length=16 with continuous valid carrying 0..15 → wraps wr_addr to 0; done fires; all 16 locations read back correctly. length=20 → clamps; exactly 16 writes occur.
- length=0 → done pulses in cycle 1; busy stays 0; RAM is unchanged.
- Valid pulse in IDLE → dropped=1, no write. The next start clears dropped. start pulsed during FILL → ignored; the transfer length is unchanged.
- Assert reset after 2 of 4 writes → IDLE, outputs 0, no done pulse. Addresses 0–1 retain their data. A fresh transfer then completes normally.
- Write 8'hAA to address 3 while rd_addr=3 in the same cycle → rd_data shows the old value; the following cycle shows 8'hAA.

Source files
------------

// File: rtl/memxfer_pkg.sv
// Constants and state encoding shared by the memory transfer path
// (controller, memory A reader and memory B writer).
package memxfer_pkg;

   localparam int MEMB_DATA_W = 8;
   localparam int MEMB_DEPTH  = 16;
   localparam int MEMB_ADDR_W = $clog2(MEMB_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } xfer_state_e;

endpackage

// File: rtl/memb_ram.sv
// Memory B storage: one write port and a registered, read-first read port.
// The array itself is never reset; only the read register is.
module memb_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Sampling the array before this edge's write lands gives read-first behaviour.
   always_comb begin
      rdata_d = mem[raddr];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/memb_writer.sv
// Destination-side writer: stores each qualified ALU result word at consecutive
// memory B addresses and pulses done once the requested length has been written.
module memb_writer #(
   parameter int DATA_W = memxfer_pkg::MEMB_DATA_W,
   parameter int DEPTH  = memxfer_pkg::MEMB_DEPTH,
   parameter int ADDR_W = memxfer_pkg::MEMB_ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   length,
   input  logic [DATA_W-1:0] datainB,
   input  logic              datain_valid,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W:0]   wr_count,
   output logic              dropped,
   output logic [1:0]        state_dbg
);

   import memxfer_pkg::*;

   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

   xfer_state_e       state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W:0]   wr_count_q, wr_count_d;
   logic              dropped_q, dropped_d;
   logic [ADDR_W:0]   len_clamped;
   logic              we;

   always_comb begin
      len_clamped = (length > DEPTH_L) ? DEPTH_L : length;
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      wr_addr_d  = wr_addr_q;
      wr_count_d = wr_count_q;
      dropped_d  = dropped_q;
      we         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (datain_valid) begin
               dropped_d = 1'b1;
            end
            // An accepted start clears dropped even if a word is dropped this cycle.
            if (start) begin
               if (len_clamped == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d    = ST_FILL;
                  len_d      = len_clamped;
                  wr_addr_d  = '0;
                  wr_count_d = '0;
                  dropped_d  = 1'b0;
               end
            end
         end
         ST_FILL: begin
            if (datain_valid) begin
               we         = 1'b1;
               wr_addr_d  = (wr_addr_q == LAST_A) ? '0 : wr_addr_q + 1'b1;
               wr_count_d = wr_count_q + 1'b1;
               if (wr_count_q == len_q - 1'b1) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (datain_valid) begin
               dropped_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         wr_addr_q  <= '0;
         wr_count_q <= '0;
         dropped_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         wr_addr_q  <= wr_addr_d;
         wr_count_q <= wr_count_d;
         dropped_q  <= dropped_d;
      end
   end

   memb_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clock (clock),
      .reset (reset),
      .we    (we),
      .waddr (wr_addr_q),
      .wdata (datainB),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   assign busy      = (state_q == ST_FILL);
   assign done      = (state_q == ST_DONE);
   assign wr_addr   = wr_addr_q;
   assign wr_count  = wr_count_q;
   assign dropped   = dropped_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_memb_writer.sv
// Self-checking bench for memb_writer: randomized transfers against an
// array model of memory B and a per-transfer model of counters and done timing.
module tb_memb_writer;

   logic       clock;
   logic       reset;
   logic       start;
   logic [4:0] length;
   logic [7:0] datainB;
   logic       datain_valid;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       busy;
   logic       done;
   logic [3:0] wr_addr;
   logic [4:0] wr_count;
   logic       dropped;
   logic [1:0] state_dbg;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem_model [16];
   bit         known [16];
   logic [7:0] data_q [$];

   memb_writer dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .length       (length),
      .datainB      (datainB),
      .datain_valid (datain_valid),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .busy         (busy),
      .done         (done),
      .wr_addr      (wr_addr),
      .wr_count     (wr_count),
      .dropped      (dropped),
      .state_dbg    (state_dbg)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic readback_all();
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a);
         step();
         if (known[a]) check($sformatf("rd[%0d]", a), rd_data, mem_model[a]);
      end
   endtask

   task automatic drop_pulse();
      datain_valid = 1'b1;
      datainB      = 8'h5A;
      step();
      datain_valid = 1'b0;
      check("dropped_set", dropped, 1);
      check("idle_no_busy", busy, 0);
      step();
      check("dropped_sticky", dropped, 1);
   endtask

   // One complete transfer: words land at addresses 0..eff-1 in order.
   task automatic run_transfer(input int len_in, input int gmin, input int gmax,
                               input bit mid_start, input bit valid_with_start);
      int eff;
      int gap;
      logic [7:0] d;
      eff = (len_in > 16) ? 16 : len_in;
      start        = 1'b1;
      length       = 5'(len_in);
      datain_valid = valid_with_start;
      datainB      = 8'hEE;
      step();
      start        = 1'b0;
      datain_valid = 1'b0;
      if (eff == 0) begin
         check("len0_done", done, 1);
         check("len0_busy", busy, 0);
         step();
         check("len0_done_off", done, 0);
         check("len0_busy_off", busy, 0);
         return;
      end
      check("busy_start", busy, 1);
      check("cnt_start", wr_count, 0);
      check("addr_start", wr_addr, 0);
      check("drop_clear", dropped, 0);
      check("no_done_start", done, 0);
      for (int i = 0; i < eff; i++) begin
         if (mid_start && i == 2) begin
            start  = 1'b1;
            length = 5'd1;
            step();
            start  = 1'b0;
            check("mid_start_busy", busy, 1);
            check("mid_start_cnt", wr_count, 2);
         end
         gap = $urandom_range(gmax, gmin);
         for (int g = 0; g < gap; g++) begin
            step();
            check("gap_hold_cnt", wr_count, 32'(i));
         end
         d = (data_q.size() > 0) ? data_q.pop_front() : 8'($urandom);
         datain_valid = 1'b1;
         datainB      = d;
         step();
         datain_valid = 1'b0;
         mem_model[i] = d;
         known[i]     = 1'b1;
         check("wr_count", wr_count, 32'(i + 1));
         check("wr_addr", wr_addr, 32'((i + 1) % 16));
         if (i < eff - 1) begin
            check("busy_mid", busy, 1);
            check("done_early", done, 0);
         end else begin
            check("done_pulse", done, 1);
            check("busy_end", busy, 0);
         end
      end
      step();
      check("done_once", done, 0);
      check("idle_busy", busy, 0);
   endtask

   initial begin
      logic [7:0] old;
      reset        = 1'b1;
      start        = 1'b0;
      length       = '0;
      datainB      = '0;
      datain_valid = 1'b0;
      rd_addr      = '0;
      for (int a = 0; a < 16; a++) known[a] = 1'b0;
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_addr", wr_addr, 0);
      check("rst_cnt", wr_count, 0);
      check("rst_drop", dropped, 0);
      check("rst_rd", rd_data, 0);
      reset = 1'b0;
      step();

      // length 4, one word every other cycle
      data_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_transfer(4, 1, 1, 1'b0, 1'b0);
      check("cnt_after4", wr_count, 4);
      readback_all();

      // full depth, continuous stream, wraps wr_addr
      for (int i = 0; i < 16; i++) data_q.push_back(8'(i));
      run_transfer(16, 0, 0, 1'b0, 1'b0);
      readback_all();

      // oversized length clamps to 16 writes
      run_transfer(20, 0, 2, 1'b0, 1'b0);
      check("clamp_cnt", wr_count, 16);
      readback_all();

      // zero length: no writes, no busy
      run_transfer(0, 0, 0, 1'b0, 1'b0);
      readback_all();

      // dropped word in IDLE, then cleared by the next start
      drop_pulse();
      readback_all();
      run_transfer(5, 0, 2, 1'b1, 1'b0);
      readback_all();

      // start and valid together in IDLE: start wins, dropped stays clear
      drop_pulse();
      run_transfer(3, 0, 1, 1'b0, 1'b1);
      readback_all();

      // reset after two of four writes
      start  = 1'b1;
      length = 5'd4;
      step();
      start  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         datainB      = 8'(8'hC0 + i);
         datain_valid = 1'b1;
         step();
         mem_model[i] = 8'(8'hC0 + i);
      end
      datain_valid = 1'b0;
      reset = 1'b1;
      #2;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_cnt", wr_count, 0);
      check("midrst_addr", wr_addr, 0);
      check("midrst_rd", rd_data, 0);
      reset = 1'b0;
      step();
      check("midrst_no_done", done, 0);
      check("midrst_idle", busy, 0);
      readback_all();
      run_transfer(4, 0, 2, 1'b0, 1'b0);
      readback_all();

      // read-first collision on address 3
      rd_addr = 4'd3;
      start   = 1'b1;
      length  = 5'd4;
      step();
      start   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         datainB      = 8'($urandom);
         datain_valid = 1'b1;
         step();
         mem_model[i] = datainB;
      end
      old          = mem_model[3];
      datainB      = 8'hAA;
      datain_valid = 1'b1;
      step();
      datain_valid = 1'b0;
      mem_model[3] = 8'hAA;
      check("rd_first_old", rd_data, old);
      check("rd_first_done", done, 1);
      step();
      check("rd_first_new", rd_data, 8'hAA);

      // randomized transfers
      for (int t = 0; t < 12; t++) begin
         run_transfer($urandom_range(20, 0), 0, $urandom_range(3, 0), 1'b0, 1'b0);
         readback_all();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
